uart_link_ctrl: RTL

//  Bus initiator for the UART peripheral register port (read/write/addr/datain/dataout).

---
 rtl/uart_link_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_link_ctrl.sv
// rtl/uart_link_ctrl.sv - UART register-port initiator with TX/RX byte FIFOs
//
// Purpose: programs the UART divisor and control registers, then polls status and
// moves bytes between two internal FIFOs and the UART TBR/RBR. Line error bits are
// captured from every status read into sticky err_flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start/div/odd   level start of (re)initialisation; divisor; parity select
//   link_up             high once initialisation has completed, until rst
//   tx_data/valid/ready client push side of the TX FIFO
//   rx_data/valid/ready client pop side of the RX FIFO
//   err_flags, err_clr  sticky {FE,OE,PE}; clear (a same-cycle set wins)
//   u_read/u_write      registered one-cycle UART strobes
//   u_addr/u_wdata      UART register address and write data
//   u_rdata             UART read data, valid the cycle after u_read

module uart_link_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module uart_link_ctrl #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic [15:0] cfg_div,
   input  logic        cfg_odd,
   output logic        link_up,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [2:0]  err_flags,
   input  logic        err_clr,
   output logic        u_read,
   output logic        u_write,
   output logic [1:0]  u_addr,
   output logic [7:0]  u_wdata,
   input  logic [7:0]  u_rdata
);
   localparam logic [1:0] A_CTL = 2'b00;
   localparam logic [1:0] A_BUF = 2'b01;
   localparam logic [1:0] A_DLO = 2'b10;
   localparam logic [1:0] A_DHI = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_W_LO, S_W_HI, S_W_CTL, S_POLL, S_P_WAIT, S_RD, S_RD_WAIT, S_WR
   } state_t;

   state_t      state_q, state_d;
   logic        u_read_q, u_read_d;
   logic        u_write_q, u_write_d;
   logic [1:0]  u_addr_q, u_addr_d;
   logic [7:0]  u_wdata_q, u_wdata_d;
   logic        link_up_q, link_up_d;
   logic [2:0]  err_q, err_d;
   logic        stat_vld_q, stat_vld_d;

   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]  tx_head;
   logic        rx_push, rx_pop, rx_full, rx_empty;

   assign tx_push = tx_valid && !tx_full;
   assign tx_pop  = (state_q == S_WR);
   assign rx_push = (state_q == S_RD_WAIT);
   assign rx_pop  = rx_ready && !rx_empty;

   uart_link_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .data_i  (tx_data),
      .pop_i   (tx_pop),
      .head_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   uart_link_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_push),
      .data_i  (u_rdata),
      .pop_i   (rx_pop),
      .head_o  (rx_data),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (cfg_start) state_d = S_W_LO;
         S_W_LO:    state_d = S_W_HI;
         S_W_HI:    state_d = S_W_CTL;
         S_W_CTL:   state_d = S_POLL;
         S_POLL:    state_d = cfg_start ? S_W_LO : S_P_WAIT;
         S_P_WAIT: begin
            // Receive side first so the UART RBR is drained before it overruns.
            if (u_rdata[6] && !rx_full)       state_d = S_RD;
            else if (u_rdata[7] && !tx_empty) state_d = S_WR;
            else                              state_d = S_POLL;
         end
         S_RD:      state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = S_POLL;
         S_WR:      state_d = S_POLL;
         default:   state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered access lines up
   // with the state that owns it; read data then arrives in the following state.
   always_comb begin
      u_read_d  = 1'b0;
      u_write_d = 1'b0;
      u_addr_d  = u_addr_q;
      u_wdata_d = u_wdata_q;
      case (state_d)
         S_W_LO: begin
            u_write_d = 1'b1;
            u_addr_d  = A_DLO;
            u_wdata_d = cfg_div[7:0];
         end
         S_W_HI: begin
            u_write_d = 1'b1;
            u_addr_d  = A_DHI;
            u_wdata_d = cfg_div[15:8];
         end
         S_W_CTL: begin
            u_write_d = 1'b1;
            u_addr_d  = A_CTL;
            u_wdata_d = {2'b00, cfg_odd, 5'b00000};
         end
         S_POLL: begin
            u_read_d = 1'b1;
            u_addr_d = A_CTL;
         end
         S_RD: begin
            u_read_d = 1'b1;
            u_addr_d = A_BUF;
         end
         S_WR: begin
            u_write_d = 1'b1;
            u_addr_d  = A_BUF;
            u_wdata_d = tx_head;
         end
         default: ;
      endcase
   end

   // Error bits are taken from every status read, including one abandoned by a
   // restart from POLL, because the UART clears them on read.
   always_comb begin
      stat_vld_d = u_read_q && (u_addr_q == A_CTL);
      link_up_d  = link_up_q || (state_q == S_W_CTL);
      err_d      = err_clr ? 3'b000 : err_q;
      if (stat_vld_q) err_d = err_d | u_rdata[5:3];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         u_read_q   <= 1'b0;
         u_write_q  <= 1'b0;
         u_addr_q   <= 2'b00;
         u_wdata_q  <= 8'h00;
         link_up_q  <= 1'b0;
         err_q      <= 3'b000;
         stat_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         u_read_q   <= u_read_d;
         u_write_q  <= u_write_d;
         u_addr_q   <= u_addr_d;
         u_wdata_q  <= u_wdata_d;
         link_up_q  <= link_up_d;
         err_q      <= err_d;
         stat_vld_q <= stat_vld_d;
      end
   end

   assign link_up   = link_up_q;
   assign err_flags = err_q;
   assign u_read    = u_read_q;
   assign u_write   = u_write_q;
   assign u_addr    = u_addr_q;
   assign u_wdata   = u_wdata_q;
   assign tx_ready  = !tx_full;
   assign rx_valid  = !rx_empty;
endmodule
